branch_resolve_ctrl: RTL
========================

// Module: branch_resolve_ctrl
// PURPOSE
//  Sits on the other side of the history predictor. It tracks each predicted branch
//  through IF->ID->EX and compares the prediction with the EX outcome. From that it
//  drives the predictor's update/rollback strobes, the pipeline flush and the redirect
//  PC. It also keeps saturating branch and mispredict statistics.
// PARAMETERS
//  JUMP_STATUS_COUNTER_WIDTH  2   width of predictor counter; MSB = predicted taken
//  FLUSH_CYCLES               1   wrong-path IF cycles after a flush (0..7) with push suppressed
//  PERF_CNT_WIDTH             32  width of statistics counters
// PORTS
//  clk              in   1   clock
//  rst_n            in   1   reset; synchronous, active-low
//  PL_stall         in   1   pipeline stall; stage tokens hold when 1
//  if_is_branch     in   1   predecoded conditional branch in IF this cycle
//  HP_count         in   JSCW  predictor counter for the IF pc
//  id_not_branch    in   1   ID decode proves the IF-predecoded branch is not a branch
//  ex_resolve       in   1   EX holds a resolved conditional branch this cycle
//  ex_branch_taken  in   1   actual EX outcome
//  pc_ex            in   32  pc of the EX instruction
//  ex_target        in   32  computed branch target in EX
//  pred_taken_if    out  1   prediction to IF: HP_count[JSCW-1]
//  corrected_en     out  1   speculative history push to predictor
//  corrected_result out  1   pushed direction (= pred_taken_if)
//  rollback_en_id   out  1   undo ID-stage speculative push
//  rollback_en_ex   out  1   EX mispredict: flip history bit, train counter
//  flush_req        out  1   kill IF/ID, redirect fetch
//  redirect_pc      out  32  fetch target when flush_req=1
//  branch_cnt       out  PCW resolved branches (saturating)
//  mispred_cnt      out  PCW mispredicted branches (saturating)
// BEHAVIOUR
//  - Reset: every output 0; tokens cleared; state RUN; flush counter 0; stats 0.
//  - Tokens: tok_id={v,p}, tok_ex={v,p}. A token advances only when PL_stall=0.
//    * tok_id <= {corrected_en, pred_taken_if}.
//    * tok_ex <= {tok_id.v & ~id_not_branch, tok_id.p}.
//  - mis = tok_ex.v & ex_resolve & ~PL_stall & (ex_branch_taken != tok_ex.p). mis is combinational.
//  - rollback_en_ex = mis. flush_req = mis.
//  - redirect_pc = ex_branch_taken ? ex_target : pc_ex + 32'd4. redirect_pc is 0 when flush_req=0.
//  - rollback_en_id = tok_id.v & ((id_not_branch & ~PL_stall) | mis).
//    When mis and a valid ID token coincide, both rollbacks assert in the same cycle.
//  - corrected_en = if_is_branch & ~PL_stall & ~mis & (state==RUN).
//  - On flush (mis=1): the next-cycle tok_id and tok_ex are cleared, overriding the advance.
//  - FSM:
//    * RUN -> FLUSH on mis when FLUSH_CYCLES>0. fcnt loads FLUSH_CYCLES.
//    * FLUSH: fcnt decrements each cycle, including stalled cycles. corrected_en=0 and tok_id.v
//      is forced 0. FLUSH -> RUN when fcnt==1.
//    * mis cannot occur in FLUSH because the EX token was cleared.
//  - Stats, counted when ex_resolve & tok_ex.v & ~PL_stall:
//    * branch_cnt += 1; mispred_cnt += mis.
//    * Both counters saturate at all-ones and never wrap.
//  - A token with ex_resolve=0 in EX retires silently: no training and no count.
//  - Mid-operation reset: all state returns to reset values in the same edge. No strobe
//    asserts in the cycle after reset.
// TESTING
//  T1 HP_count=2'b10, if_is_branch=1, stall=0 -> corrected_en=1, corrected_result=1;
//     two cycles later ex_resolve=1, taken=1 -> no flush; branch_cnt=1, mispred_cnt=0.
//  T2 predicted taken, actual not-taken, pc_ex=0x100 -> rollback_en_ex=1, flush_req=1,
//     redirect_pc=0x104; next cycle corrected_en=0 for FLUSH_CYCLES=1; mispred_cnt=1.
//  T3 predicted not-taken, actual taken, ex_target=0x2000, valid branch token in ID ->
//     rollback_en_ex=1 and rollback_en_id=1 in the same cycle; redirect_pc=0x2000.
//  T4 branch pushed, then id_not_branch=1 -> rollback_en_id=1; EX later sees no token,
//     so no rollback_en_ex and no count even with ex_resolve=1.
//  T5 PL_stall=1 for 3 cycles while the EX token mispredicts -> no strobes during the stall;
//     exactly one rollback_en_ex pulse when the stall drops; counts increment once.
//  T6 preload mispred_cnt to all-ones via a PCW=4 build, then one more mispredict ->
//     mispred_cnt stays at 4'hF; assert rst_n=0 mid-FLUSH -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: tracks predicted branches IF->ID->EX, drives rollback/flush/redirect and keeps stats.
module branch_resolve_ctrl #(
    parameter int JUMP_STATUS_COUNTER_WIDTH = 2,
    parameter int FLUSH_CYCLES              = 1,
    parameter int PERF_CNT_WIDTH            = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 PL_stall,
    input  logic                                 if_is_branch,
    input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] HP_count,
    input  logic                                 id_not_branch,
    input  logic                                 ex_resolve,
    input  logic                                 ex_branch_taken,
    input  logic [31:0]                          pc_ex,
    input  logic [31:0]                          ex_target,
    output logic                                 pred_taken_if,
    output logic                                 corrected_en,
    output logic                                 corrected_result,
    output logic                                 rollback_en_id,
    output logic                                 rollback_en_ex,
    output logic                                 flush_req,
    output logic [31:0]                          redirect_pc,
    output logic [PERF_CNT_WIDTH-1:0]            branch_cnt,
    output logic [PERF_CNT_WIDTH-1:0]            mispred_cnt
);
    typedef enum logic {RUN, FLUSH} state_t;
    state_t                    state_q, state_d;
    logic [2:0]                fcnt_q, fcnt_d;
    logic                      tid_v_q, tid_p_q, tex_v_q, tex_p_q;
    logic                      tid_v_d, tid_p_d, tex_v_d, tex_p_d;
    logic [PERF_CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;
    logic                      mis, counted;
    logic                      unused_hp;

    assign unused_hp = ^HP_count[JUMP_STATUS_COUNTER_WIDTH-2:0];

    // Outputs are gated by rst_n so nothing strobes while reset is held.
    always_comb begin
        mis              = rst_n & tex_v_q & ex_resolve & ~PL_stall & (ex_branch_taken != tex_p_q);
        counted          = tex_v_q & ex_resolve & ~PL_stall;
        pred_taken_if    = rst_n & HP_count[JUMP_STATUS_COUNTER_WIDTH-1];
        corrected_en     = rst_n & if_is_branch & ~PL_stall & ~mis & (state_q == RUN);
        corrected_result = pred_taken_if;
        rollback_en_id   = rst_n & tid_v_q & ((id_not_branch & ~PL_stall) | mis);
        rollback_en_ex   = mis;
        flush_req        = mis;
        redirect_pc      = mis ? (ex_branch_taken ? ex_target : pc_ex + 32'd4) : 32'd0;
        branch_cnt       = branch_cnt_q;
        mispred_cnt      = mispred_cnt_q;
    end

    always_comb begin
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        tid_v_d       = tid_v_q;
        tid_p_d       = tid_p_q;
        tex_v_d       = tex_v_q;
        tex_p_d       = tex_p_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (state_q == FLUSH) begin
            fcnt_d = fcnt_q - 3'd1;
            if (fcnt_q == 3'd1) state_d = RUN;
        end else if (mis && FLUSH_CYCLES > 0) begin
            state_d = FLUSH;
            fcnt_d  = 3'(FLUSH_CYCLES);
        end
        if (mis) begin
            tid_v_d = 1'b0;
            tex_v_d = 1'b0;
        end else if (!PL_stall) begin
            tid_v_d = corrected_en;
            tid_p_d = pred_taken_if;
            tex_v_d = tid_v_q & ~id_not_branch;
            tex_p_d = tid_p_q;
        end
        if (counted && branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + PERF_CNT_WIDTH'(1);
        if (mis && mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + PERF_CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RUN;
            fcnt_q        <= 3'd0;
            tid_v_q       <= 1'b0;
            tid_p_q       <= 1'b0;
            tex_v_q       <= 1'b0;
            tex_p_q       <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            tid_v_q       <= tid_v_d;
            tid_p_q       <= tid_p_d;
            tex_v_q       <= tex_v_d;
            tex_p_q       <= tex_p_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end
endmodule
